// File: rtl/truth_table_scanner_pkg.sv
// Shared constants and state encoding for the truth table scanner.
package truth_table_scanner_pkg;

  localparam int MINTERM_W = 3;
  localparam int TABLE_W = 8;
  localparam logic [TABLE_W-1:0] DEFAULT_EXPECTED = 8'hE0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    FINISH = 2'd3
  } scan_state_t;

endpackage

// File: rtl/truth_table_scanner_if.sv
// Scanner-side (master) and function-block-side (slave) view of the scan bus.
interface truth_table_scanner_if;
  import truth_table_scanner_pkg::*;

  logic                 start;
  logic                 s;
  logic                 a;
  logic                 b;
  logic                 c;
  logic [MINTERM_W-1:0] m;
  logic                 busy;
  logic                 done;
  logic [TABLE_W-1:0]   truth_table;
  logic                 match;

  modport master (
    input  start, s,
    output a, b, c, m, busy, done, truth_table, match
  );

  modport slave (
    output start, s,
    input  a, b, c, m, busy, done, truth_table, match
  );

endinterface

// File: rtl/truth_table_scanner_scan_settle_cnt.sv
// 4-bit loadable down-counter; last flags the final settle cycle of a minterm.
module scan_settle_cnt (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_value,
  output logic       last
);

  logic [3:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= 4'd0;
    end else if (load) begin
      count_q <= load_value;
    end else if (count_q != 4'd0) begin
      count_q <= count_q - 4'd1;
    end
  end

  assign last = (count_q == 4'd1);

endmodule

// File: rtl/truth_table_scanner.sv
// Walks minterms 0..7 on a/b/c, captures s into an 8-bit truth table.
// Define SCAN_COMPARE_EN to build the comparator that drives match.
module truth_table_scanner
  import truth_table_scanner_pkg::*;
#(
  parameter int                 SETTLE   = 1,
  parameter logic [TABLE_W-1:0] EXPECTED = DEFAULT_EXPECTED
) (
  input logic                   clk,
  input logic                   reset,
  truth_table_scanner_if.master bus
);

  if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
    $error("truth_table_scanner: SETTLE must be in 1..15");
  end

  scan_state_t          state_q;
  scan_state_t          state_d;
  logic [MINTERM_W-1:0] m_q;
  logic [TABLE_W-1:0]   table_q;
  logic [TABLE_W-1:0]   table_sampled;
  logic                 load_cnt;
  logic                 cnt_last;
  logic                 m_last;

  assign m_last = (m_q == 3'd7);

  scan_settle_cnt u_settle_cnt (
    .clk        (clk),
    .reset      (reset),
    .load       (load_cnt),
    .load_value (4'(SETTLE)),
    .last       (cnt_last)
  );

  // The counter is reloaded whenever we are not settling, so every DRIVE entry starts at SETTLE.
  always_comb begin
    state_d  = state_q;
    load_cnt = 1'b0;
    case (state_q)
      IDLE: begin
        load_cnt = 1'b1;
        if (bus.start) state_d = DRIVE;
      end
      DRIVE: begin
        if (cnt_last) state_d = SAMPLE;
      end
      SAMPLE: begin
        load_cnt = 1'b1;
        state_d  = m_last ? FINISH : DRIVE;
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    table_sampled      = table_q;
    table_sampled[m_q] = bus.s;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q     <= '0;
      table_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            m_q     <= '0;
            table_q <= '0;
          end
        end
        SAMPLE: begin
          table_q <= table_sampled;
          if (!m_last) m_q <= m_q + 3'd1;
        end
        FINISH: begin
          m_q <= '0;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef SCAN_COMPARE_EN
  logic match_q;

  // Compared against the table including the final sample, so match is valid alongside done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match_q <= 1'b0;
    end else if (state_q == IDLE && bus.start) begin
      match_q <= 1'b0;
    end else if (state_q == SAMPLE && m_last) begin
      match_q <= (table_sampled == EXPECTED);
    end
  end

  assign bus.match = match_q;
`else
  logic unused_expected;
  assign unused_expected = ^EXPECTED;
  assign bus.match       = 1'b0;
`endif

  assign {bus.a, bus.b, bus.c} = m_q;
  assign bus.m                 = m_q;
  assign bus.busy              = (state_q == DRIVE) || (state_q == SAMPLE);
  assign bus.done              = (state_q == FINISH);
  assign bus.truth_table       = table_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Self-checking bench: known functions from a vector table, random functions, and corner sequences.
module tb_truth_table_scanner;
  import truth_table_scanner_pkg::*;

  localparam int               SETTLE      = 3;
  localparam logic [7:0]       EXPECTED    = 8'hE0;
  localparam int               SCAN_CYCLES = 8 * (SETTLE + 1);

  typedef struct {
    int         func_sel;
    logic [7:0] tt;
    string      name;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  int   func_sel = 0;
  logic [7:0] rand_tt = 8'h00;
  vec_t vecs [6];

  always #5 clk = ~clk;

  truth_table_scanner_if bus ();

  truth_table_scanner #(
    .SETTLE   (SETTLE),
    .EXPECTED (EXPECTED)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // The function under test, selectable per scan.
  always_comb begin
    bus.s = 1'b0;
    case (func_sel)
      0:       bus.s = (bus.a & bus.b) | (bus.a & bus.c);
      1:       bus.s = bus.a ^ bus.b ^ bus.c;
      2:       bus.s = 1'b1;
      3:       bus.s = 1'b0;
      4:       bus.s = bus.c;
      5:       bus.s = bus.a & ~bus.b;
      default: bus.s = rand_tt[{bus.a, bus.b, bus.c}];
    endcase
  end

  function automatic logic expMatch(input logic [7:0] tt);
`ifdef SCAN_COMPARE_EN
    return tt == EXPECTED;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] pack(input logic busy, input logic done, input logic [2:0] m,
                                       input logic [2:0] abc, input logic [7:0] tbl, input logic mt);
    return {15'd0, busy, done, m, abc, tbl, mt};
  endfunction

  function automatic logic [31:0] observed();
    return pack(bus.busy, bus.done, bus.m, {bus.a, bus.b, bus.c}, bus.truth_table, bus.match);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // One full scan from start to the first idle cycle; pulse_at injects a start while busy.
  task automatic applyStimulus(input string tag, input logic [7:0] exp_tt, input int pulse_at, input bit hold);
    bus.start = 1'b1;
    @(posedge clk); #1;
    if (!hold) bus.start = 1'b0;
    for (int j = 0; j < SCAN_CYCLES; j++) begin
      int         idx;
      logic [8:0] mask;
      idx  = j / (SETTLE + 1);
      mask = (9'd1 << idx) - 9'd1;
      checkOutput($sformatf("%s cycle %0d", tag, j), observed(),
                  pack(1'b1, 1'b0, 3'(idx), 3'(idx), exp_tt & mask[7:0], 1'b0));
      if (j == pulse_at) bus.start = 1'b1;
      else if (!hold) bus.start = 1'b0;
      @(posedge clk); #1;
    end
    checkOutput({tag, " done/busy"}, {30'd0, bus.busy, bus.done}, 32'd1);
    checkOutput({tag, " table"}, {24'd0, bus.truth_table}, {24'd0, exp_tt});
    checkOutput({tag, " match"}, {31'd0, bus.match}, {31'd0, expMatch(exp_tt)});
    @(posedge clk); #1;
    checkOutput({tag, " idle"}, observed(), pack(1'b0, 1'b0, 3'd0, 3'd0, exp_tt, expMatch(exp_tt)));
  endtask

  initial begin
    vecs[0] = '{0, 8'hE0, "majority_a"};
    vecs[1] = '{1, 8'h96, "parity"};
    vecs[2] = '{2, 8'hFF, "const1"};
    vecs[3] = '{3, 8'h00, "const0"};
    vecs[4] = '{4, 8'hAA, "c_only"};
    vecs[5] = '{5, 8'h30, "a_and_not_b"};

    reset     = 1'b1;
    bus.start = 1'b0;
    #1;
    checkOutput("reset state", observed(), pack(1'b0, 1'b0, 3'd0, 3'd0, 8'h00, 1'b0));
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("after reset", observed(), pack(1'b0, 1'b0, 3'd0, 3'd0, 8'h00, 1'b0));

    for (int v = 0; v < 6; v++) begin
      func_sel = vecs[v].func_sel;
      applyStimulus(vecs[v].name, vecs[v].tt, -1, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput({vecs[v].name, " held"}, observed(),
                  pack(1'b0, 1'b0, 3'd0, 3'd0, vecs[v].tt, expMatch(vecs[v].tt)));
    end

    // Reset after a completed scan clears the held table and match.
    reset = 1'b1;
    #1;
    checkOutput("reset clears held", observed(), pack(1'b0, 1'b0, 3'd0, 3'd0, 8'h00, 1'b0));
    @(posedge clk); #1;
    reset = 1'b0;

    // Reset in the middle of a scan.
    func_sel  = 2;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3 * (SETTLE + 1)) @(posedge clk);
    #1;
    checkOutput("pre-reset m", {29'd0, bus.m}, 32'd3);
    reset = 1'b1;
    #1;
    checkOutput("reset mid-scan", observed(), pack(1'b0, 1'b0, 3'd0, 3'd0, 8'h00, 1'b0));
    @(posedge clk); #1;
    checkOutput("reset held", observed(), pack(1'b0, 1'b0, 3'd0, 3'd0, 8'h00, 1'b0));
    reset = 1'b0;
    @(posedge clk); #1;
    applyStimulus("post-reset", 8'hFF, -1, 1'b0);

    // Start pulsed while busy at m=2 is ignored.
    func_sel = 0;
    applyStimulus("start-busy", 8'hE0, 2 * (SETTLE + 1), 1'b0);

    // Start held high: back-to-back scans, table cleared at each start.
    func_sel = 3;
    applyStimulus("b2b first", 8'h00, -1, 1'b1);
    func_sel = 2;
    applyStimulus("b2b second", 8'hFF, -1, 1'b1);
    bus.start = 1'b0;
    @(posedge clk); #1;

    // Random functions against the truth-table model.
    for (int r = 0; r < 6; r++) begin
      rand_tt  = 8'($urandom);
      func_sel = 6;
      applyStimulus($sformatf("rand%0d", r), rand_tt, -1, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
